// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of external JK flip-flops.
// It applies masked hold/clear/set/toggle patterns or runs a ripple up/down count over len+1 cycles.
module jk_bank_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [3:0]       cmd_len,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, APPLY, RUN, DONE} state_t;

  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_SET    = 3'b010;
  localparam logic [2:0] OP_TOGGLE = 3'b011;
  localparam logic [2:0] OP_UP     = 3'b100;
  localparam logic [2:0] OP_DOWN   = 3'b101;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] mask_q;
  logic [3:0]       len_q;
  logic [3:0]       cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic [3:0]       cnt_d;
  logic             is_count_op;

  assign cnt_d       = cnt_q + 4'd1;
  assign is_count_op = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            mask_q  <= cmd_mask;
            len_q   <= cmd_len;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= is_count_op ? RUN : APPLY;
          end
        end
        APPLY: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        RUN: begin
          if (cnt_q == len_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Toggle-enable chains: a bit flips when every lower bit is 1 (up) or 0 (down).
  logic [WIDTH-1:0] up_c;
  logic [WIDTH-1:0] dn_c;
  logic [WIDTH-1:0] run_t;
  logic             in_apply;
  logic             in_run;

  assign in_apply = (state_q == APPLY);
  assign in_run   = (state_q == RUN);
  assign up_c[0]  = 1'b1;
  assign dn_c[0]  = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign up_c[gi] = up_c[gi-1] & q[gi-1];
      assign dn_c[gi] = dn_c[gi-1] & ~q[gi-1];
    end
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign run_t[gi] = (op_q == OP_UP) ? up_c[gi] : dn_c[gi];
      assign j[gi] = (in_apply && mask_q[gi] && ((op_q == OP_SET) || (op_q == OP_TOGGLE)))
                   || (in_run && run_t[gi]);
      assign k[gi] = (in_apply && mask_q[gi] && ((op_q == OP_CLEAR) || (op_q == OP_TOGGLE)))
                   || (in_run && run_t[gi]);
    end
  endgenerate

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl driving a 4-bit behavioural JK bank; expected bank values
// come from an arithmetic model and flow through a scoreboard queue.
module tb_jk_bank_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_mask = 4'd0;
  logic [3:0] cmd_len = 4'd0;
  logic [3:0] q;
  logic [3:0] j;
  logic [3:0] k;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cur_q = 4'd0;

  jk_bank_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_len(cmd_len), .q(q),
    .j(j), .k(k), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 4'd0;
    else        q <= (j & ~q) | (~k & q);
  end

  function automatic logic [3:0] model(input logic [2:0] op, input logic [3:0] mask,
                                       input logic [3:0] len, input logic [3:0] qin);
    case (op)
      3'b001:  return qin & ~mask;
      3'b010:  return qin | mask;
      3'b011:  return qin ^ mask;
      3'b100:  return qin + len + 4'd1;
      3'b101:  return qin - len - 4'd1;
      default: return qin;
    endcase
  endfunction

  // Called on a falling edge; returns on the falling edge after cmd_ready comes back.
  task automatic issue(input logic [2:0] op, input logic [3:0] mask, input logic [3:0] len,
                       output int wait_n, output int lat, output int busy_n,
                       output logic [3:0] q_done, output logic [3:0] j_first,
                       output logic [3:0] k_first, output logic rdy_after, output logic ok);
    cmd_op = op; cmd_mask = mask; cmd_len = len; cmd_valid = 1'b1;
    wait_n = 0;
    while (!cmd_ready && wait_n < 50) begin
      @(negedge clk); wait_n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_mask = ~mask;
    lat = 1; j_first = j; k_first = k; busy_n = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk); lat++;
      if (busy) busy_n++;
    end
    q_done = q;
    @(negedge clk);
    rdy_after = cmd_ready;
    ok = (wait_n < 50) && (lat < 40);
    $display("txn op=%b mask=%b len=%0d wait=%0d lat=%0d busy=%0d q=%b", op, mask, len,
             wait_n, lat, busy_n, q_done);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (j !== 4'd0 || k !== 4'd0) begin bad++; $display("FAIL reset_jk got=%b/%b want=0000/0000", j, k); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    total++; if (q !== 4'd0) begin bad++; $display("FAIL reset_q got=%b want=0000", q); end
    rst_n = 1'b1;
    cur_q = 4'd0;
  endtask

  task automatic run_single(input string nm, input logic [2:0] op, input logic [3:0] mask,
                            input logic [3:0] ej, input logic [3:0] ek);
    int w, l, b; logic [3:0] qd, jf, kf, e; logic r, ok;
    cur_q = model(op, mask, 4'd0, cur_q);
    exp_q.push_back(cur_q);
    issue(op, mask, 4'd0, w, l, b, qd, jf, kf, r, ok);
    e = exp_q.pop_front();
    total++; if (!ok) begin bad++; $display("FAIL %s_timeout got=wait%0d/lat%0d want=bounded", nm, w, l); end
    total++; if (qd !== e) begin bad++; $display("FAIL %s_q got=%b want=%b", nm, qd, e); end
    total++; if (l !== 2) begin bad++; $display("FAIL %s_latency got=%0d want=2", nm, l); end
    total++; if (jf !== ej || kf !== ek) begin bad++; $display("FAIL %s_jk got=%b/%b want=%b/%b", nm, jf, kf, ej, ek); end
    total++; if (r !== 1'b1) begin bad++; $display("FAIL %s_ready_after got=%b want=1", nm, r); end
  endtask

  task automatic test_set();
    run_single("set", 3'b010, 4'b0101, 4'b0101, 4'b0000);
  endtask

  task automatic test_toggle_clear_reserved();
    run_single("toggle", 3'b011, 4'b0011, 4'b0011, 4'b0011);
    run_single("clear", 3'b001, 4'b1111, 4'b0000, 4'b1111);
    run_single("reserved", 3'b111, 4'b1111, 4'b0000, 4'b0000);
  endtask

  task automatic run_count(input string nm, input logic [2:0] op, input logic [3:0] len,
                           input logic [3:0] want_q);
    int w, l, b; logic [3:0] qd, jf, kf, e; logic r, ok;
    cur_q = model(op, 4'b1010, len, cur_q);
    exp_q.push_back(cur_q);
    issue(op, 4'b1010, len, w, l, b, qd, jf, kf, r, ok);
    e = exp_q.pop_front();
    total++; if (!ok) begin bad++; $display("FAIL %s_timeout got=wait%0d/lat%0d want=bounded", nm, w, l); end
    total++; if (qd !== e || qd !== want_q) begin bad++; $display("FAIL %s_q got=%b want=%b", nm, qd, e); end
    total++; if (l !== int'(len) + 2) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, l, int'(len) + 2); end
    total++; if (b !== int'(len) + 1) begin bad++; $display("FAIL %s_busy_cycles got=%0d want=%0d", nm, b, int'(len) + 1); end
    total++; if (jf[0] !== 1'b1 || kf[0] !== 1'b1) begin bad++; $display("FAIL %s_bit0_jk got=%b/%b want=1/1", nm, jf[0], kf[0]); end
    total++; if (r !== 1'b1) begin bad++; $display("FAIL %s_ready_after got=%b want=1", nm, r); end
  endtask

  task automatic test_count_up();
    run_count("count_up4", 3'b100, 4'd4, 4'b0101);
  endtask

  task automatic test_count_wrap();
    run_single("clear0", 3'b001, 4'b1111, 4'b0000, 4'b1111);
    run_count("count_down0", 3'b101, 4'd0, 4'b1111);
    run_count("count_up15", 3'b100, 4'd15, 4'b1111);
  endtask

  task automatic test_reset_abort();
    int w, l, b, dn; logic [3:0] qd, jf, kf, e; logic r, ok;
    run_single("clear1", 3'b001, 4'b1111, 4'b0000, 4'b1111);
    cmd_op = 3'b100; cmd_len = 4'd7; cmd_mask = 4'b0000; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b1 || q !== 4'd2) begin bad++; $display("FAIL abort_pre got=busy%b/q%b want=busy1/q0010", busy, q); end
    rst_n = 1'b0;
    #1;
    total++; if (j !== 4'd0 || k !== 4'd0) begin bad++; $display("FAIL abort_jk got=%b/%b want=0000/0000", j, k); end
    total++; if (q !== 4'd0) begin bad++; $display("FAIL abort_q got=%b want=0000", q); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_status got=b%b d%b r%b want=b0 d0 r1", busy, done, cmd_ready); end
    dn = 0;
    repeat (2) begin @(negedge clk); if (done) dn++; end
    total++; if (dn !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dn); end
    rst_n = 1'b1;
    cur_q = model(3'b010, 4'b1010, 4'd0, 4'd0);
    exp_q.push_back(cur_q);
    issue(3'b010, 4'b1010, 4'd0, w, l, b, qd, jf, kf, r, ok);
    e = exp_q.pop_front();
    total++; if (w !== 0) begin bad++; $display("FAIL first_accept_wait got=%0d want=0", w); end
    total++; if (qd !== e || l !== 2 || !ok) begin bad++; $display("FAIL first_accept_q got=%b/lat%0d want=%b/lat2", qd, l, e); end
  endtask

  task automatic test_back_to_back();
    int n, nacc, ndone, pend;
    int acc_idx[2];
    int done_idx[2];
    logic [3:0] e;
    acc_idx = '{-1, -1}; done_idx = '{-1, -1};
    cur_q = model(3'b011, 4'b1111, 4'd0, cur_q);
    exp_q.push_back(cur_q);
    cur_q = model(3'b100, 4'b0000, 4'd1, cur_q);
    exp_q.push_back(cur_q);
    cmd_op = 3'b011; cmd_mask = 4'b1111; cmd_len = 4'd0; cmd_valid = 1'b1;
    n = 0; nacc = 0; ndone = 0; pend = 0;
    while (ndone < 2 && n < 60) begin
      if (cmd_valid && cmd_ready) begin
        if (nacc < 2) acc_idx[nacc] = n;
        nacc++; pend = nacc;
      end
      @(negedge clk); n++;
      if (pend == 1) begin cmd_op = 3'b100; cmd_mask = 4'b0000; cmd_len = 4'd1; end
      if (pend == 2) cmd_valid = 1'b0;
      pend = 0;
      if (done) begin
        if (ndone < 2) done_idx[ndone] = n;
        ndone++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
        $display("txn b2b done=%0d q=%b", ndone, q);
        total++; if (q !== e) begin bad++; $display("FAIL b2b_q%0d got=%b want=%b", ndone, q, e); end
      end
    end
    cmd_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (cmd_ready && cmd_valid) nacc++;
      if (done) ndone++;
    end
    total++; if (nacc !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d want=2", nacc); end
    total++; if (ndone !== 2) begin bad++; $display("FAIL b2b_dones got=%0d want=2", ndone); end
    total++; if (acc_idx[1] !== done_idx[0] + 1) begin bad++; $display("FAIL b2b_second_accept got=%0d want=%0d", acc_idx[1], done_idx[0] + 1); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_toggle_clear_reserved();
    test_count_up();
    test_count_wrap();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/jk_bank_ctrl.md
JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, setting the number of JK flip-flops in the controlled bank.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1, command present.
REQ-005 SHALL have port cmd_ready, output, 1, controller can accept a command.
REQ-006 SHALL have port cmd_op, input, 3, operation code (REQ-012).
REQ-007 SHALL have port cmd_mask, input, WIDTH, per-bit select for HOLD/CLEAR/SET/TOGGLE.
REQ-008 SHALL have port cmd_len, input, 4, count steps minus one for count ops.
REQ-009 SHALL have port q, input, WIDTH, current outputs of the JK bank.
REQ-010 SHALL have ports j and k, outputs, WIDTH each, drive the bank's J and K inputs.
REQ-011 SHALL have ports busy and done, outputs, 1 each: command executing, and one-cycle completion pulse.

Function
REQ-012 Opcodes SHALL be: 000 HOLD, 001 CLEAR, 010 SET, 011 TOGGLE, 100 COUNT_UP, 101 COUNT_DOWN; 110 and 111 execute as HOLD.
REQ-013 States SHALL be IDLE, APPLY, RUN, DONE, held in a registered state machine.
REQ-014 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-015 On accept, op, mask, and len SHALL be latched; later input changes have no effect until the next accept.
REQ-016 Accepted single-step ops (HOLD, CLEAR, SET, TOGGLE, reserved) SHALL go IDLE->APPLY; count ops SHALL go IDLE->RUN.
REQ-017 APPLY SHALL last exactly one cycle, then go to DONE.
REQ-018 In APPLY, masked bits SHALL be driven as follows: CLEAR j=0,k=1; SET j=1,k=0; TOGGLE j=1,k=1; HOLD j=0,k=0.
REQ-019 In APPLY, unmasked bits SHALL be j=0,k=0.
REQ-020 RUN SHALL last exactly len+1 cycles using an internal step counter, then go to DONE.
REQ-021 In RUN, bit 0 SHALL be driven j=k=1 every cycle, and cmd_mask SHALL be ignored.
REQ-022 In RUN with COUNT_UP, bit i>0 SHALL be driven j=k=AND(q[i-1:0]); with COUNT_DOWN, j=k=AND(~q[i-1:0]).
REQ-023 The count SHALL wrap modulo 2^WIDTH (up: all-ones->0; down: 0->all-ones) with no flag.
REQ-024 j and k SHALL be combinational from state, latched op/mask, and q; they SHALL be all-zero in IDLE and DONE.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-026 busy SHALL be 1 in APPLY and RUN, else 0.
REQ-027 Latency SHALL be: single-step ops done 2 cycles after the accept edge; count ops done len+2 cycles after it; cmd_ready returns the cycle after done.
REQ-028 cmd_valid held high during busy/DONE SHALL NOT be accepted; it SHALL be accepted on the first IDLE edge.
REQ-029 No command SHALL be lost or duplicated.

Reset
REQ-030 While rst_n=0, regardless of clk: state=IDLE, j=0, k=0, busy=0, done=0, cmd_ready=1, step counter=0, latched op/mask/len=0.
REQ-031 Assertion of rst_n mid-APPLY or mid-RUN SHALL abort the command immediately with no done pulse.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (bench connects WIDTH=4 JK flip-flops sharing clk/rst_n to j/k/q)
REQ-033 Reset, q=0000; SET mask=0101 -> q=0101 after APPLY edge, done pulse 2 cycles after accept, cmd_ready back next cycle.
REQ-034 q=0101; TOGGLE mask=0011 -> q=0110; then CLEAR mask=1111 -> q=0000; reserved op 111 -> q unchanged, done pulses.
REQ-035 q=0000; COUNT_UP len=4 -> q=0101 after 5 RUN cycles, busy high 5 cycles, done at cycle 6 after accept.
REQ-036 q=0000; COUNT_DOWN len=0 -> q=1111 (wrap); COUNT_UP len=15 from 1111 -> q=1111 (full wrap, 16 steps).
REQ-037 rst_n pulsed low at third RUN cycle of COUNT_UP len=7 -> j=k=0 and q=0000 immediately, no done, cmd_ready=1.
REQ-038 cmd_valid held high with two different commands back to back -> each accepted exactly once, second accepted the cycle after the first done.
